// File: rtl/lane_arb_pkg.sv
// Shared types, sizes and the rotate-priority pick function for the lane mux arbiter.
package lane_arb_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned LANE_W    = 2;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } lane_state_e;

  typedef struct packed {
    logic              found;
    logic [LANE_W-1:0] idx;
  } rr_pick_t;

  // First set request scanning upward from ptr, wrapping modulo NUM_LANES.
  function automatic rr_pick_t rr_pick(input logic [NUM_LANES-1:0] req,
                                       input logic [LANE_W-1:0]    ptr);
    rr_pick_t          r;
    logic [LANE_W-1:0] lane;
    r = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      lane = ptr + LANE_W'(i);
      if (req[lane] && !r.found) begin
        r.found = 1'b1;
        r.idx   = lane;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lane_mux_arbiter_pick.sv
// Combinational rotate-priority encoder: picks the first requesting lane at or after ptr.
module lane_rr_pick
  import lane_arb_pkg::*;
(
  input  logic [NUM_LANES-1:0] req,
  input  logic [LANE_W-1:0]    ptr,
  output logic [LANE_W-1:0]    idx,
  output logic                 found
);

  rr_pick_t pick;

  always_comb begin
    pick  = rr_pick(req, ptr);
    idx   = pick.idx;
    found = pick.found;
  end

endmodule

// File: rtl/lane_mux_arbiter.sv
// Round-robin owner of the shared 4:1 lane mux, one dead cycle between owners.
// Optional per-lane grant counters are enabled by defining LANE_ARB_GRANT_CNT_EN.
module lane_mux_arbiter
  import lane_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] req,
  output logic [LANE_W-1:0]    sel,
  output logic [NUM_LANES-1:0] grant,
  output logic                 sel_vld,
  output logic                 timeout
`ifdef LANE_ARB_GRANT_CNT_EN
  ,
  output logic [NUM_LANES*CNT_W-1:0] grant_cnt
`endif
);

  localparam int unsigned HOLD_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  lane_state_e            state, state_nxt;
  logic [LANE_W-1:0]      rr_ptr, rr_ptr_d;
  logic [HOLD_W-1:0]      hold_cnt, hold_d;
  logic [LANE_W-1:0]      sel_d;
  logic [NUM_LANES-1:0]   grant_d;
  logic                   sel_vld_d, timeout_d;
  logic                   timed_out;
  logic [LANE_W-1:0]      pick_idx;
  logic                   pick_found;

  lane_rr_pick u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      grant    <= '0;
      sel_vld  <= 1'b0;
      timeout  <= 1'b0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_d;
      grant    <= grant_d;
      sel_vld  <= sel_vld_d;
      timeout  <= timeout_d;
      rr_ptr   <= rr_ptr_d;
      hold_cnt <= hold_d;
    end
  end

  // sel doubles as the current owner while in GRANT.
  always_comb begin
    state_nxt = state;
    timed_out = 1'b0;
    unique case (state)
      IDLE, GAP: state_nxt = pick_found ? GRANT : IDLE;
      GRANT: begin
        if (!req[sel]) begin
          state_nxt = GAP;
        end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST)) begin
          state_nxt = GAP;
          timed_out = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs are computed from the state being entered.
  always_comb begin
    sel_d     = sel;
    grant_d   = '0;
    sel_vld_d = 1'b0;
    timeout_d = 1'b0;
    rr_ptr_d  = rr_ptr;
    hold_d    = '0;
    unique case (state_nxt)
      GRANT: begin
        if (state != GRANT) begin
          sel_d  = pick_idx;
          hold_d = '0;
        end else begin
          hold_d = (hold_cnt == '1) ? hold_cnt : hold_cnt + HOLD_W'(1);
        end
        grant_d   = NUM_LANES'(1) << sel_d;
        sel_vld_d = 1'b1;
      end
      GAP: begin
        rr_ptr_d  = sel + LANE_W'(1);
        timeout_d = timed_out;
      end
      default: ;
    endcase
  end

`ifdef LANE_ARB_GRANT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
    end else if ((state != GRANT) && (state_nxt == GRANT)) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        if ((pick_idx == LANE_W'(i)) && (grant_cnt[i*CNT_W +: CNT_W] != '1)) begin
          grant_cnt[i*CNT_W +: CNT_W] <= grant_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_lane_mux_arbiter.sv
// Scoreboard bench: two arbiters (MAX_HOLD=4 and MAX_HOLD=0) share clk/rst/req, each against its own model.
module tb_lane_mux_arbiter;

  localparam int CW = 2;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] grant;
    logic       vld;
    logic       to;
    logic [7:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;

  logic [1:0] sel_a, sel_b;
  logic [3:0] grant_a, grant_b;
  logic       vld_a, vld_b, to_a, to_b;
  logic [7:0] cnt_a, cnt_b;

  int vectors = 0;
  int miscompares = 0;

  exp_t q[2][$];

  // Model: owner lane (-1 = none), cycles held, lane priority order, grant counts.
  int own[2];
  int held[2];
  int order[2][4];
  int gcnt[2][4];
  int last_sel[2];
  int maxh[2];

  always #5 clk = ~clk;

  lane_mux_arbiter #(.MAX_HOLD(4), .CNT_W(CW)) dut_a (
    .clk(clk), .rst(rst), .req(req), .sel(sel_a), .grant(grant_a),
    .sel_vld(vld_a), .timeout(to_a)
`ifdef LANE_ARB_GRANT_CNT_EN
    , .grant_cnt(cnt_a)
`endif
  );

  lane_mux_arbiter #(.MAX_HOLD(0), .CNT_W(CW)) dut_b (
    .clk(clk), .rst(rst), .req(req), .sel(sel_b), .grant(grant_b),
    .sel_vld(vld_b), .timeout(to_b)
`ifdef LANE_ARB_GRANT_CNT_EN
    , .grant_cnt(cnt_b)
`endif
  );

`ifndef LANE_ARB_GRANT_CNT_EN
  assign cnt_a = '0;
  assign cnt_b = '0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      own[m] = -1;
      held[m] = 0;
      last_sel[m] = 0;
      for (int i = 0; i < 4; i++) begin
        order[m][i] = i;
        gcnt[m][i] = 0;
      end
      q[m].delete();
    end
  endtask

  task automatic model_step(input int m, input logic [3:0] r);
    exp_t e;
    bit   ended;
    e.to  = 1'b0;
    ended = 1'b0;
    if (own[m] >= 0) begin
      if (!r[own[m]]) begin
        ended = 1'b1;
      end else if (maxh[m] != 0 && held[m] == maxh[m]) begin
        ended = 1'b1;
        e.to  = 1'b1;
      end else begin
        held[m]++;
      end
      if (ended) begin
        // Served lane drops to the back of the priority order.
        for (int i = 0; i < 4; i++) order[m][i] = (own[m] + 1 + i) % 4;
        own[m] = -1;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (own[m] < 0 && r[order[m][i]]) begin
          own[m] = order[m][i];
          held[m] = 1;
          last_sel[m] = own[m];
          if (gcnt[m][own[m]] < (1 << CW) - 1) gcnt[m][own[m]]++;
        end
      end
    end
    e.sel   = 2'(last_sel[m]);
    e.grant = (own[m] >= 0) ? 4'(1 << own[m]) : 4'd0;
    e.vld   = (own[m] >= 0);
    e.cnt   = '0;
`ifdef LANE_ARB_GRANT_CNT_EN
    for (int i = 0; i < 4; i++) e.cnt[i*CW +: CW] = CW'(gcnt[m][i]);
`endif
    q[m].push_back(e);
  endtask

  task automatic cyc(input logic [3:0] r);
    @(negedge clk);
    req = r;
    model_step(0, r);
    model_step(1, r);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    #1;
    check("rst_grant_a", {28'd0, grant_a}, 0);
    check("rst_sel_a", {30'd0, sel_a}, 0);
    check("rst_vld_to_a", {30'd0, vld_a, to_a}, 0);
    check("rst_grant_b", {28'd0, grant_b}, 0);
    check("rst_vld_to_b", {30'd0, vld_b, to_b}, 0);
    check("rst_cnt", {16'd0, cnt_a, cnt_b}, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  exp_t ea, eb;
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (q[0].size() > 0) begin
        ea = q[0].pop_front();
        check("a_sel", {30'd0, sel_a}, {30'd0, ea.sel});
        check("a_grant", {28'd0, grant_a}, {28'd0, ea.grant});
        check("a_vld", {31'd0, vld_a}, {31'd0, ea.vld});
        check("a_timeout", {31'd0, to_a}, {31'd0, ea.to});
        check("a_grant_cnt", {24'd0, cnt_a}, {24'd0, ea.cnt});
      end
      if (q[1].size() > 0) begin
        eb = q[1].pop_front();
        check("b_sel", {30'd0, sel_b}, {30'd0, eb.sel});
        check("b_grant", {28'd0, grant_b}, {28'd0, eb.grant});
        check("b_vld", {31'd0, vld_b}, {31'd0, eb.vld});
        check("b_timeout", {31'd0, to_b}, {31'd0, eb.to});
        check("b_grant_cnt", {24'd0, cnt_b}, {24'd0, eb.cnt});
      end
    end
  end

  initial begin
    logic [3:0] r;
    maxh[0] = 4;
    maxh[1] = 0;
    model_reset();
    apply_reset();

    // Single lane 2 tenure of three cycles, then a gap and idle.
    repeat (3) cyc(4'b0100);
    repeat (3) cyc(4'b0000);

    // All lanes requesting: timeout rotation on the MAX_HOLD=4 instance.
    repeat (24) cyc(4'b1111);
    repeat (2) cyc(4'b0000);

    // Lane 0 drops after two cycles; lane 3 is next, lane 0 waits its turn.
    apply_reset();
    repeat (2) cyc(4'b1001);
    repeat (3) cyc(4'b1000);
    repeat (4) cyc(4'b1001);
    repeat (2) cyc(4'b0000);

    // Reset while lane 2 owns the mux, then lanes 1 and 2 request.
    apply_reset();
    repeat (2) cyc(4'b0100);
    apply_reset();
    repeat (4) cyc(4'b0110);
    repeat (2) cyc(4'b0000);

    // Long continuous request on lane 0.
    repeat (300) cyc(4'b0001);
    repeat (2) cyc(4'b0000);

    // Five separate lane-1 tenures saturate a 2-bit counter.
    apply_reset();
    repeat (5) begin
      repeat (2) cyc(4'b0010);
      repeat (2) cyc(4'b0000);
    end

    // Random request patterns held for a few cycles each.
    r = 4'(($urandom() & 32'hF));
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      cyc(r);
    end

    @(negedge clk);
    @(negedge clk);
    check("a_queue_drained", q[0].size(), 0);
    check("b_queue_drained", q[1].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
